// File: rtl/ad_bus_pkg.sv
// Shared types and default widths for the AD bus initiator.
package ad_bus_pkg;

  localparam int unsigned AD_AW      = 32;
  localparam int unsigned AD_DW      = 16;
  localparam int unsigned AD_TIMEOUT = 16;

  typedef enum logic [2:0] {
    AD_IDLE  = 3'd0,
    AD_ADDR  = 3'd1,
    AD_WDATA = 3'd2,
    AD_TURN  = 3'd3,
    AD_RDATA = 3'd4,
    AD_RESP  = 3'd5
  } ad_state_t;

  // True in the states where the target may complete with bus_rdy.
  function automatic logic is_data_phase(input ad_state_t s);
    return (s == AD_WDATA) || (s == AD_RDATA);
  endfunction

endpackage

// File: rtl/ad_bus_timeout_ctr.sv
// Data-phase wait-state counter. expired means TIMEOUT-1 cycles have already
// passed without bus_rdy, so one more such cycle reaches the limit.
module ad_bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;

  assign count_inc = count + CW'(1);

  // Count missed cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      count   <= count_inc;
      expired <= (count_inc == LAST);
    end
  end

endmodule

// File: rtl/ad_bus_initiator.sv
// Single-outstanding initiator for the multiplexed address/data bus.
// All bus and handshake outputs are registered from the next state.
module ad_bus_initiator
  import ad_bus_pkg::*;
#(
  parameter int unsigned AW      = AD_AW,
  parameter int unsigned DW      = AD_DW,
  parameter int unsigned TIMEOUT = AD_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ad_out,
  output logic          ad_oe,
  input  logic [AW-1:0] ad_in,
  output logic          ale,
  output logic          rd_n,
  output logic          wr_n,
  input  logic          bus_rdy
);

  ad_state_t state;
  ad_state_t state_next;

  logic          wr_q;
  logic [DW-1:0] wdata_q;

  logic          accept;
  logic          done_ok;
  logic          done_to;
  logic          ctr_clear;
  logic          ctr_en;
  logic          expired;

  logic          ready_d;
  logic          rsp_valid_d;
  logic          ad_oe_d;
  logic          ale_d;
  logic          rd_n_d;
  logic          wr_n_d;
  logic [AW-1:0] ad_out_d;

  ad_bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= AD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and transfer-completion strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    case (state)
      AD_IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = AD_ADDR;
        end
      end
      AD_ADDR: begin
        ctr_clear  = 1'b1;
        state_next = wr_q ? AD_WDATA : AD_TURN;
      end
      AD_TURN: begin
        ctr_clear  = 1'b1;
        state_next = AD_RDATA;
      end
      AD_WDATA, AD_RDATA: begin
        if (bus_rdy) begin
          done_ok    = 1'b1;
          state_next = AD_RESP;
        end else if (expired) begin
          done_to    = 1'b1;
          state_next = AD_RESP;
        end else begin
          ctr_en = is_data_phase(state);
        end
      end
      AD_RESP: begin
        if (rsp_ready) begin
          state_next = AD_IDLE;
        end
      end
      default: state_next = AD_IDLE;
    endcase
  end

  // Bus and handshake values for the state being entered.
  always_comb begin
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    ad_oe_d     = 1'b0;
    ale_d       = 1'b0;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    ad_out_d    = '0;
    case (state_next)
      AD_IDLE:  ready_d = 1'b1;
      AD_ADDR: begin
        // Only reachable from IDLE, so the request port still holds the address.
        ad_oe_d  = 1'b1;
        ale_d    = 1'b1;
        ad_out_d = req_addr;
      end
      AD_WDATA: begin
        ad_oe_d  = 1'b1;
        wr_n_d   = 1'b0;
        ad_out_d = AW'(wdata_q);
      end
      AD_RDATA: rd_n_d = 1'b0;
      AD_RESP:  rsp_valid_d = 1'b1;
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Registered bus and handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      ad_oe     <= 1'b0;
      ale       <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ad_out    <= '0;
    end else begin
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      ad_oe     <= ad_oe_d;
      ale       <= ale_d;
      rd_n      <= rd_n_d;
      wr_n      <= wr_n_d;
      ad_out    <= ad_out_d;
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      wdata_q <= req_wdata;
    end
  end

  // Response payload, loaded once per transfer and held through RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done_ok) begin
      rsp_rdata <= wr_q ? '0 : ad_in[DW-1:0];
      rsp_err   <= 1'b0;
    end else if (done_to) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

  // Upper AD bits carry no read data.
  if (DW < AW) begin : g_ad_hi
    logic unused_ad_hi;
    assign unused_ad_hi = ^ad_in[AW-1:DW];
  end

endmodule

// File: tb/tb_ad_bus_initiator.sv
// Scoreboard bench for ad_bus_initiator: expected responses queued on accept,
// checked on the response handshake; bus timing checked inline per scenario.
module tb_ad_bus_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ad_out;
  logic          ad_oe;
  logic [AW-1:0] ad_in;
  logic          ale;
  logic          rd_n;
  logic          wr_n;
  logic          bus_rdy;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_rd_n = 1'b1;

  ad_bus_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in),
    .ale       (ale),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .bus_rdy   (bus_rdy)
  );

  always #5 clk = ~clk;

  // Scoreboard and contention monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if ((ad_oe && !rd_n) !== 1'b0) begin
        n_fail++; $display("FAIL contention_same_cycle: ad_oe=%b rd_n=%b", ad_oe, rd_n);
      end
      n_checks++;
      if ((ad_oe && !prev_rd_n) !== 1'b0) begin
        n_fail++; $display("FAIL contention_after_read: ad_oe=%b prev rd_n=%b", ad_oe, prev_rd_n);
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_unexpected_rsp: rdata=%h err=%b with nothing outstanding", rsp_rdata, rsp_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (rsp_rdata !== e.rdata) begin
            n_fail++; $display("FAIL sb_rdata: got %h expected %h", rsp_rdata, e.rdata);
          end
          n_checks++;
          if (rsp_err !== e.err) begin
            n_fail++; $display("FAIL sb_err: got %b expected %b", rsp_err, e.err);
          end
        end
      end
    end
    prev_rd_n = rd_n;
  end

  // Present a request until accepted; queue its expected response.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] er, input bit ee);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL issue_accept: req_ready stayed %b for addr %h", req_ready, a);
    end else begin
      exp_q.push_back('{rdata: er, err: ee});
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  // Wait for the response handshake within a cycle budget.
  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%b rsp_ready=%b", tag, rsp_valid, rsp_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (ad_out !== '0) begin n_fail++; $display("FAIL rst_ad_out: got %h expected 0", ad_out); end
    n_checks++; if (ad_oe !== 1'b0) begin n_fail++; $display("FAIL rst_ad_oe: got %b expected 0", ad_oe); end
    n_checks++; if (ale !== 1'b0) begin n_fail++; $display("FAIL rst_ale: got %b expected 0", ale); end
    n_checks++; if (rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n: got %b expected 1", rd_n); end
    n_checks++; if (wr_n !== 1'b1) begin n_fail++; $display("FAIL rst_wr_n: got %b expected 1", wr_n); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    bus_rdy = 1'b1;
    issue(1'b1, 32'h0000_1234, 16'hBEEF, 16'h0000, 1'b0);
    @(negedge clk);  // ADDR
    n_checks++; if (ale !== 1'b1) begin n_fail++; $display("FAIL wr_ale: got %b expected 1", ale); end
    n_checks++; if (ad_oe !== 1'b1) begin n_fail++; $display("FAIL wr_addr_oe: got %b expected 1", ad_oe); end
    n_checks++; if (ad_out !== 32'h0000_1234) begin n_fail++; $display("FAIL wr_addr: got %h expected 00001234", ad_out); end
    @(negedge clk);  // WDATA
    n_checks++; if (ad_out !== 32'h0000_BEEF) begin n_fail++; $display("FAIL wr_data: got %h expected 0000beef", ad_out); end
    n_checks++; if (wr_n !== 1'b0) begin n_fail++; $display("FAIL wr_wr_n: got %b expected 0", wr_n); end
    n_checks++; if (ale !== 1'b0) begin n_fail++; $display("FAIL wr_ale_drop: got %b expected 0", ale); end
    @(negedge clk);  // RESP, three cycles after accept
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_latency: rsp_valid got %b expected 1", rsp_valid); end
    n_checks++; if ({ad_oe, wr_n} !== 2'b01) begin n_fail++; $display("FAIL wr_resp_idle: ad_oe,wr_n got %b expected 01", {ad_oe, wr_n}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL wr_back_idle: ready,valid got %b expected 10", {req_ready, rsp_valid}); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_wait();
    bus_rdy = 1'b0;
    ad_in = 32'h1111_2222;
    issue(1'b0, 32'h0000_0040, 16'h0000, 16'hA5A5, 1'b0);
    @(negedge clk);  // ADDR
    n_checks++; if (ad_out !== 32'h0000_0040) begin n_fail++; $display("FAIL rd_addr: got %h expected 00000040", ad_out); end
    @(negedge clk);  // TURN
    n_checks++; if ({ad_oe, rd_n} !== 2'b01) begin n_fail++; $display("FAIL rd_turn: ad_oe,rd_n got %b expected 01", {ad_oe, rd_n}); end
    @(negedge clk);  // RDATA wait 1
    n_checks++; if (rd_n !== 1'b0) begin n_fail++; $display("FAIL rd_rd_n: got %b expected 0", rd_n); end
    @(posedge clk); #1;  // wait 2
    @(posedge clk); #1;  // wait 3
    @(posedge clk); #1;  // target completes
    bus_rdy = 1'b1;
    ad_in = 32'hDEAD_A5A5;
    @(posedge clk); #1;
    bus_rdy = 1'b0;
    ad_in = 32'h1111_2222;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL rd_rdata: got %h expected a5a5", rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bus_rdy = 1'b0;
    ad_in = 32'h0000_7777;
    issue(1'b0, 32'h0000_0080, 16'h0000, 16'h0000, 1'b1);
    repeat (17) @(negedge clk);  // through 15th RDATA cycle
    @(negedge clk);              // 16th RDATA cycle
    n_checks++; if ({rsp_valid, rd_n} !== 2'b00) begin n_fail++; $display("FAIL to_early: valid,rd_n got %b expected 00", {rsp_valid, rd_n}); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_rsp_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", rsp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout_edge();
    bus_rdy = 1'b0;
    ad_in = 32'h0000_7777;
    issue(1'b0, 32'h0000_00C0, 16'h0000, 16'h5A5A, 1'b0);
    repeat (17) @(posedge clk);
    #1;  // 16th RDATA cycle
    bus_rdy = 1'b1;
    ad_in = 32'hFFFF_5A5A;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL toe_early: rsp_valid got %b expected 0", rsp_valid); end
    @(posedge clk); #1;
    bus_rdy = 1'b0;
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL toe_success: valid,err got %b expected 10", {rsp_valid, rsp_err}); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    rsp_ready = 1'b0;
    bus_rdy = 1'b1;
    ad_in = 32'h0000_C3C3;
    issue(1'b0, 32'h0000_0200, 16'h0000, 16'hC3C3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_seen: got %b expected 1", seen); end
    @(posedge clk); #1;
    ad_in = 32'h0000_0000;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0300; req_wdata = 16'h2468;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, rsp_valid); end
      n_checks++; if (rsp_rdata !== 16'hC3C3) begin n_fail++; $display("FAIL bp_hold_rdata[%0d]: got %h expected c3c3", i, rsp_rdata); end
      n_checks++; if ({req_ready, ale} !== 2'b00) begin n_fail++; $display("FAIL bp_no_accept[%0d]: ready,ale got %b expected 00", i, {req_ready, ale}); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{rdata: 16'h0000, err: 1'b0});
    @(negedge clk);
    n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_after_hs: ready,valid got %b expected 10", {req_ready, rsp_valid}); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ad_out !== 32'h0000_0300) begin n_fail++; $display("FAIL bp_next_addr: got %h expected 00000300", ad_out); end
    drain("bp");
  endtask

  task automatic test_reset_midflight();
    bus_rdy = 1'b0;
    issue(1'b1, 32'h0000_0500, 16'hAAAA, 16'h0000, 1'b0);
    @(negedge clk);  // ADDR
    @(negedge clk);  // WDATA
    n_checks++; if (wr_n !== 1'b0) begin n_fail++; $display("FAIL mr_in_wdata: wr_n got %b expected 0", wr_n); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if ({ad_oe, wr_n, rd_n, ale} !== 4'b0110) begin n_fail++; $display("FAIL mr_bus_reset: oe,wr_n,rd_n,ale got %b expected 0110", {ad_oe, wr_n, rd_n, ale}); end
    n_checks++; if (ad_out !== '0) begin n_fail++; $display("FAIL mr_ad_out: got %h expected 0", ad_out); end
    n_checks++; if ({req_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL mr_handshake: ready,valid got %b expected 00", {req_ready, rsp_valid}); end
    bus_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL mr_idle: ready,valid got %b expected 10", {req_ready, rsp_valid}); end
    @(posedge clk); #1;
    issue(1'b1, 32'h0000_0600, 16'h1111, 16'h0000, 1'b0);
    @(negedge clk);
    n_checks++; if (ad_out !== 32'h0000_0600) begin n_fail++; $display("FAIL mr_next_addr: got %h expected 00000600", ad_out); end
    @(negedge clk);
    n_checks++; if (ad_out !== 32'h0000_1111) begin n_fail++; $display("FAIL mr_next_data: got %h expected 00001111", ad_out); end
    drain("mr");
  endtask

  task automatic test_back_to_back();
    bus_rdy = 1'b1;
    ad_in = 32'h9999_0F0F;
    issue(1'b0, 32'h0000_0700, 16'h0000, 16'h0F0F, 1'b0);
    @(negedge clk);  // ADDR
    n_checks++; if (ale !== 1'b1) begin n_fail++; $display("FAIL b2b_ale: got %b expected 1", ale); end
    for (int i = 0; i < 3; i++) begin  // TURN, RDATA, RESP
      @(negedge clk);
      n_checks++; if (ad_oe !== 1'b0) begin n_fail++; $display("FAIL b2b_oe_low[%0d]: got %b expected 0", i, ad_oe); end
    end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_latency: rsp_valid got %b expected 1", rsp_valid); end
    @(posedge clk); #1;
    issue(1'b1, 32'h0000_0704, 16'h3C3C, 16'h0000, 1'b0);
    @(negedge clk);
    n_checks++; if ({ad_oe, ale} !== 2'b11) begin n_fail++; $display("FAIL b2b_wr_addr: oe,ale got %b expected 11", {ad_oe, ale}); end
    drain("b2b");
  endtask

  // Hard stop so the run can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    ad_in     = '0;
    bus_rdy   = 1'b0;

    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_timeout_edge();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
